// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage of the pipeline.
// Issues loads/stores from EX/MEM as req/ack transactions on a multi-cycle data
// memory, stalls upstream while a transaction is outstanding, and registers the
// MEM/WB fields for the writeback stage.
// Optional feature macro: MEM_TIMEOUT_EN (aborts a transaction that sees no ack
// within TIMEOUT_CYCLES wait cycles and pulses bus_err).
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_M,
    input  logic        RegWr_M,
    input  logic        MemWr_M,
    input  logic        MemtoReg_M,
    input  logic [4:0]  wreg_M,
    input  logic [31:0] result_M,
    input  logic [31:0] rt_data_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        RegWr_W,
    output logic [4:0]  wreg_W,
    output logic [31:0] wdata_W
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;
    logic        regwr_w_q, regwr_w_d;
    logic [4:0]  wreg_w_q, wreg_w_d;
    logic [31:0] wdata_w_q, wdata_w_d;

    logic acc;
    logic aligned;
    logic timeout;

    assign acc     = valid_M & (MemWr_M | MemtoReg_M);
    assign aligned = (result_M[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Abort fires on the last permitted no-ack wait cycle; an ack in that cycle wins.
    assign timeout = (state_q == S_WAIT) & ~dmem_ack &
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;

    assign unused_cfg = (TIMEOUT_CYCLES != CNT_W);
    assign timeout    = 1'b0;
`endif

    // Hold the upstream pipeline while a request is being issued or awaited.
    assign stall = ((state_q == S_IDLE) & acc & aligned) |
                   ((state_q == S_WAIT) & ~dmem_ack & ~timeout);

    // Next-state and next-output computation for the access FSM and MEM/WB fields.
    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        misalign_d   = 1'b0;
        bus_err_d    = 1'b0;
        regwr_w_d    = 1'b0;
        wreg_w_d     = wreg_w_q;
        wdata_w_d    = wdata_w_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (acc && aligned) begin
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = MemWr_M;
                    dmem_addr_d  = result_M;
                    dmem_wdata_d = rt_data_M;
                    state_d      = S_WAIT;
`ifdef MEM_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end else if (acc) begin
                    misalign_d = 1'b1;
                    wreg_w_d   = wreg_M;
                    wdata_w_d  = 32'h0;
                end else begin
                    regwr_w_d = RegWr_M & valid_M;
                    wreg_w_d  = wreg_M;
                    wdata_w_d = result_M;
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    state_d    = S_IDLE;
                    regwr_w_d  = RegWr_M;
                    wreg_w_d   = wreg_M;
                    wdata_w_d  = MemtoReg_M ? dmem_rdata : result_M;
                end else if (timeout) begin
                    dmem_req_d = 1'b0;
                    state_d    = S_IDLE;
                    bus_err_d  = 1'b1;
                    wreg_w_d   = wreg_M;
                    wdata_w_d  = 32'h0;
                end else begin
`ifdef MEM_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d    = S_IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset overrides any concurrent ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'h0;
            dmem_wdata_q <= 32'h0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            regwr_w_q    <= 1'b0;
            wreg_w_q     <= 5'h0;
            wdata_w_q    <= 32'h0;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
            regwr_w_q    <= regwr_w_d;
            wreg_w_q     <= wreg_w_d;
            wdata_w_q    <= wdata_w_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign misalign   = misalign_q;
    assign bus_err    = bus_err_q;
    assign RegWr_W    = regwr_w_q;
    assign wreg_W     = wreg_w_q;
    assign wdata_W    = wdata_w_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit.
// Expected memory requests and writeback results are queued when an instruction
// is presented and compared when the DUT issues the request / updates MEM/WB.
module tb_mem_access_unit;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_M, RegWr_M, MemWr_M, MemtoReg_M;
    logic [4:0]  wreg_M;
    logic [31:0] result_M, rt_data_M;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall, misalign, bus_err, RegWr_W;
    logic [4:0]  wreg_W;
    logic [31:0] wdata_W;

    typedef struct {
        logic        regwr;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        mis;
        logic        berr;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    wb_t  wbQ[$];
    req_t reqQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    mem_access_unit #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_M(valid_M),
        .RegWr_M(RegWr_M),
        .MemWr_M(MemWr_M),
        .MemtoReg_M(MemtoReg_M),
        .wreg_M(wreg_M),
        .result_M(result_M),
        .rt_data_M(rt_data_M),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .stall(stall),
        .misalign(misalign),
        .bus_err(bus_err),
        .RegWr_W(RegWr_W),
        .wreg_W(wreg_W),
        .wdata_W(wdata_W)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ackDelay: cycle after the request edge in which ack arrives (1 = minimum);
    // 0 means the memory never answers (timeout build only).
    task automatic applyStimulus(input logic v, input logic rw, input logic mw, input logic mr,
                                 input logic [4:0] wr, input logic [31:0] res, input logic [31:0] rtd,
                                 input int ackDelay, input logic [31:0] rdata);
        logic acc;
        logic aligned;
        wb_t  e;
        req_t r;
        acc     = v & (mw | mr);
        aligned = (res[1:0] == 2'b00);
        if (acc && aligned) begin
            r.we = mw; r.addr = res; r.wdata = rtd;
            reqQ.push_back(r);
            if (ackDelay == 0) e = '{1'b0, wr, 32'h0, 1'b0, 1'b1};
            else               e = '{rw, wr, (mr ? rdata : res), 1'b0, 1'b0};
        end else if (acc) begin
            e = '{1'b0, wr, 32'h0, 1'b1, 1'b0};
        end else begin
            e = '{rw & v, wr, res, 1'b0, 1'b0};
        end
        wbQ.push_back(e);

        valid_M = v; RegWr_M = rw; MemWr_M = mw; MemtoReg_M = mr;
        wreg_M = wr; result_M = res; rt_data_M = rtd;
        #1;
        checkOutput("stall_issue", stall, acc && aligned);

        if (acc && aligned) begin
            tick;
            r = reqQ.pop_front();
            checkOutput("dmem_req", dmem_req, 1'b1);
            checkOutput("dmem_we", dmem_we, r.we);
            checkOutput("dmem_addr", dmem_addr, r.addr);
            checkOutput("dmem_wdata", dmem_wdata, r.wdata);
            if (ackDelay == 0) begin
                for (int i = 1; i < TIMEOUT; i++) begin
                    checkOutput("stall_wait", stall, 1'b1);
                    tick;
                end
                checkOutput("stall_timeout", stall, 1'b0);
                tick;
            end else begin
                for (int i = 1; i < ackDelay; i++) begin
                    checkOutput("stall_wait", stall, 1'b1);
                    checkOutput("addr_hold", dmem_addr, r.addr);
                    tick;
                end
                dmem_ack = 1'b1;
                dmem_rdata = rdata;
                #1;
                checkOutput("stall_ack", stall, 1'b0);
                tick;
                dmem_ack = 1'b0;
                dmem_rdata = $urandom;
            end
            checkOutput("dmem_req_drop", dmem_req, 1'b0);
        end else begin
            tick;
            checkOutput("no_req", dmem_req, 1'b0);
        end

        e = wbQ.pop_front();
        checkOutput("RegWr_W", RegWr_W, e.regwr);
        checkOutput("wreg_W", wreg_W, e.wreg);
        checkOutput("wdata_W", wdata_W, e.wdata);
        checkOutput("misalign", misalign, e.mis);
        checkOutput("bus_err", bus_err, e.berr);
    endtask

    // Main sequence: reset, directed cases, random mix, timeout, reset in WAIT.
    initial begin
        int kind;
        logic [31:0] rnd;
        rst = 1'b1;
        valid_M = 0; RegWr_M = 0; MemWr_M = 0; MemtoReg_M = 0;
        wreg_M = 0; result_M = 0; rt_data_M = 0;
        dmem_ack = 0; dmem_rdata = 0;
        tick;
        tick;
        checkOutput("rst_req", dmem_req, 1'b0);
        checkOutput("rst_addr", dmem_addr, 32'h0);
        checkOutput("rst_wdata", dmem_wdata, 32'h0);
        checkOutput("rst_RegWr_W", RegWr_W, 1'b0);
        checkOutput("rst_wdata_W", wdata_W, 32'h0);
        checkOutput("rst_misalign", misalign, 1'b0);
        checkOutput("rst_bus_err", bus_err, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("rst_stall", stall, 1'b0);

        applyStimulus(1, 1, 0, 1, 5'd5, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        applyStimulus(1, 0, 1, 0, 5'd3, 32'h20, 32'h1234, 1, 32'h0BAD0BAD);
        applyStimulus(1, 1, 0, 0, 5'd9, 32'd7, 32'h0, 0, 32'h0);
        applyStimulus(1, 1, 0, 1, 5'd6, 32'h102, 32'h0, 1, 32'h0);
        applyStimulus(1, 1, 0, 0, 5'd10, 32'h55AA, 32'h0, 0, 32'h0);
        applyStimulus(0, 1, 0, 1, 5'd11, 32'hAA, 32'h0, 1, 32'h0);
        applyStimulus(1, 1, 0, 1, 5'd12, 32'h200, 32'h0, 2, 32'h11112222);
        applyStimulus(1, 1, 0, 1, 5'd13, 32'h204, 32'h0, 1, 32'h33334444);

        for (int n = 0; n < 8; n++) begin
            kind = $urandom_range(0, 3);
            rnd  = $urandom;
            case (kind)
                0: applyStimulus(1, 1, 0, 0, 5'($urandom_range(1, 31)), rnd, $urandom, 0, 32'h0);
                1: applyStimulus(1, 1, 0, 1, 5'($urandom_range(1, 31)), {rnd[31:2], 2'b00}, 32'h0,
                                 $urandom_range(1, 4), $urandom);
                2: applyStimulus(1, 0, 1, 0, 5'($urandom_range(1, 31)), {rnd[31:2], 2'b00}, $urandom,
                                 $urandom_range(1, 4), $urandom);
                default: applyStimulus(1, 1, 0, 1, 5'($urandom_range(1, 31)),
                                       {rnd[31:2], 2'($urandom_range(1, 3))}, 32'h0, 1, 32'h0);
            endcase
        end

`ifdef MEM_TIMEOUT_EN
        applyStimulus(1, 1, 0, 1, 5'd14, 32'h400, 32'h0, 0, 32'h0);
        applyStimulus(1, 1, 0, 1, 5'd15, 32'h404, 32'h0, TIMEOUT, 32'hA5A5A5A5);
`else
        applyStimulus(1, 1, 0, 1, 5'd14, 32'h400, 32'h0, 20, 32'h5A5A5A5A);
`endif

        // Reset while waiting, with an ack in the same cycle and another one later.
        valid_M = 1; RegWr_M = 1; MemWr_M = 0; MemtoReg_M = 1;
        wreg_M = 5'd7; result_M = 32'h300; rt_data_M = 0;
        tick;
        checkOutput("rstw_req_issued", dmem_req, 1'b1);
        rst = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        tick;
        checkOutput("rstw_req", dmem_req, 1'b0);
        checkOutput("rstw_addr", dmem_addr, 32'h0);
        checkOutput("rstw_RegWr_W", RegWr_W, 1'b0);
        checkOutput("rstw_wreg_W", wreg_W, 5'd0);
        checkOutput("rstw_wdata_W", wdata_W, 32'h0);
        rst = 1'b0;
        valid_M = 0; MemtoReg_M = 0; result_M = 32'h55;
        tick;
        dmem_ack = 1'b0;
        checkOutput("late_ack_RegWr_W", RegWr_W, 1'b0);
        checkOutput("late_ack_wdata_W", wdata_W, 32'h55);
        checkOutput("late_ack_req", dmem_req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Hard time limit so a stuck run still ends with a verdict.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got 0x%08h, expected 0x%08h", 0, 1);
        failCount++;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
